// File: rtl/bist_pe_scan_ctrl.sv
// BIST fault-scan controller: walks every PE of a ROWS x COLS systolic array, mirrors its
// operands into the redundant MAC and records PEs whose bottom output disagrees with the RMAC.
module bist_pe_scan_ctrl #(
  parameter int ROWS          = 2,
  parameter int COLS          = 2,
  parameter int WORD_SIZE     = 16,
  parameter int SETTLE_CYCLES = 4,
  localparam int N   = ROWS * COLS,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int FCW = $clog2(ROWS * COLS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop_on_fail,
  input  logic [ROWS*WORD_SIZE-1:0]      left_in_bus,
  input  logic [COLS*WORD_SIZE-1:0]      top_in_bus,
  input  logic [ROWS*COLS*WORD_SIZE-1:0] hor_interconnect,
  input  logic [ROWS*COLS*WORD_SIZE-1:0] ver_interconnect,
  input  logic [WORD_SIZE-1:0]           rmac_bottom_out,
  output logic [WORD_SIZE-1:0]           rmac_left_in,
  output logic [WORD_SIZE-1:0]           rmac_top_in,
  output logic [RW-1:0]                  cur_row,
  output logic [CW-1:0]                  cur_col,
  output logic                           busy,
  output logic                           done,
  output logic [N-1:0]                   fault_map,
  output logic [FCW-1:0]                 fault_count,
  output logic                           fail
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, DONE} state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   row_nxt;
  logic [CW-1:0]   col_nxt;
  logic [SW-1:0]   cnt, cnt_nxt;
  logic            sof, sof_nxt;
  logic [N-1:0]    map_nxt;
  logic [FCW-1:0]  count_nxt;
  logic [N-1:0]    pe_sel;
  logic [WORD_SIZE-1:0] expected;
  logic            mismatch;
  logic            last_pe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur_row     <= '0;
      cur_col     <= '0;
      cnt         <= '0;
      sof         <= 1'b0;
      fault_map   <= '0;
      fault_count <= '0;
    end else begin
      state       <= state_nxt;
      cur_row     <= row_nxt;
      cur_col     <= col_nxt;
      cnt         <= cnt_nxt;
      sof         <= sof_nxt;
      fault_map   <= map_nxt;
      fault_count <= count_nxt;
    end
  end

  // Operand steering and expected-result select, decoded from the registered PE index.
  // Clamped indices keep the unused left/top branches of edge PEs inside the bus.
  always_comb begin
    pe_sel       = '0;
    expected     = '0;
    rmac_left_in = '0;
    rmac_top_in  = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (cur_row == RW'(r) && cur_col == CW'(c)) begin
          pe_sel[r*COLS+c] = 1'b1;
          expected = ver_interconnect[(r*COLS+c)*WORD_SIZE +: WORD_SIZE];
          if (c == 0)
            rmac_left_in = left_in_bus[r*WORD_SIZE +: WORD_SIZE];
          else
            rmac_left_in = hor_interconnect[((r*COLS+c > 0) ? r*COLS+c-1 : 0)*WORD_SIZE +: WORD_SIZE];
          if (r == 0)
            rmac_top_in = top_in_bus[c*WORD_SIZE +: WORD_SIZE];
          else
            rmac_top_in = ver_interconnect[((r > 0) ? (r-1)*COLS+c : 0)*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = cur_row;
    col_nxt   = cur_col;
    cnt_nxt   = cnt;
    sof_nxt   = sof;
    map_nxt   = fault_map;
    count_nxt = fault_count;
    busy      = 1'b0;
    done      = 1'b0;
    mismatch  = (rmac_bottom_out != expected);
    last_pe   = (cur_row == RW'(ROWS-1)) && (cur_col == CW'(COLS-1));
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          map_nxt   = '0;
          count_nxt = '0;
          row_nxt   = '0;
          col_nxt   = '0;
          cnt_nxt   = '0;
          sof_nxt   = stop_on_fail;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        busy    = 1'b1;
        cnt_nxt = cnt + SW'(1);
        if (cnt == SW'(SETTLE_CYCLES-1))
          state_nxt = COMPARE;
      end
      COMPARE: begin
        busy = 1'b1;
        if (mismatch) begin
          map_nxt   = fault_map | pe_sel;
          count_nxt = fault_count + FCW'(1);
        end
        if (last_pe || (mismatch && sof)) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt   = '0;
          state_nxt = SETTLE;
          if (cur_col == CW'(COLS-1)) begin
            col_nxt = '0;
            row_nxt = cur_row + RW'(1);
          end else begin
            col_nxt = cur_col + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fail = |fault_map;

endmodule

// File: tb/tb_bist_pe_scan_ctrl.sv
// Scoreboard bench for bist_pe_scan_ctrl: a timeline model predicts every cycle's outputs and
// each scan's final result; a monitor pops and compares on the falling edge.
module tb_bist_pe_scan_ctrl;
  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int W    = 16;
  localparam int S    = 4;
  localparam int N    = ROWS * COLS;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int FCW  = $clog2(N + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                stop_on_fail = 1'b0;
  logic [ROWS*W-1:0]   left_in_bus = '0;
  logic [COLS*W-1:0]   top_in_bus = '0;
  logic [N*W-1:0]      hor_interconnect = '0;
  logic [N*W-1:0]      ver_interconnect = '0;
  logic [W-1:0]        rmac_bottom_out = '0;
  logic [W-1:0]        rmac_left_in, rmac_top_in;
  logic [RW-1:0]       cur_row;
  logic [CW-1:0]       cur_col;
  logic                busy, done, fail;
  logic [N-1:0]        fault_map;
  logic [FCW-1:0]      fault_count;

  bist_pe_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail),
    .left_in_bus(left_in_bus), .top_in_bus(top_in_bus),
    .hor_interconnect(hor_interconnect), .ver_interconnect(ver_interconnect),
    .rmac_bottom_out(rmac_bottom_out), .rmac_left_in(rmac_left_in), .rmac_top_in(rmac_top_in),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy), .done(done),
    .fault_map(fault_map), .fault_count(fault_count), .fail(fail)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Array word images; PE index p = r*COLS + c.
  logic [W-1:0] lw [ROWS];
  logic [W-1:0] tw [COLS];
  logic [W-1:0] hw [N];
  logic [W-1:0] vw [N];

  typedef struct {
    logic         busy;
    logic         done;
    logic [N-1:0] map;
    int           row;
    int           col;
    logic [W-1:0] l;
    logic [W-1:0] t;
  } cyc_t;

  typedef struct {
    logic [N-1:0] map;
    int           row;
    int           col;
    int           at;
  } res_t;

  cyc_t cq[$];
  res_t rq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_left(input int p);
    return (p % COLS == 0) ? lw[p / COLS] : hw[p - 1];
  endfunction

  function automatic logic [W-1:0] exp_top(input int p);
    return (p / COLS == 0) ? tw[p % COLS] : vw[p - COLS];
  endfunction

  function automatic logic [N-1:0] first_bits(input int n);
    logic [N-1:0] m = '0;
    for (int i = 0; i < N; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  task automatic drive_inputs(input bit directed);
    for (int r = 0; r < ROWS; r++) lw[r] = W'($urandom);
    for (int c = 0; c < COLS; c++) tw[c] = W'($urandom);
    for (int p = 0; p < N; p++) begin
      hw[p] = W'($urandom);
      vw[p] = W'($urandom);
    end
    if (directed) begin
      hw[2] = 16'h0A0A;
      vw[1] = 16'h0B0B;
    end
    for (int r = 0; r < ROWS; r++) left_in_bus[r*W +: W] = lw[r];
    for (int c = 0; c < COLS; c++) top_in_bus[c*W +: W] = tw[c];
    for (int p = 0; p < N; p++) begin
      hor_interconnect[p*W +: W] = hw[p];
      ver_interconnect[p*W +: W] = vw[p];
    end
  endtask

  task automatic push(input logic b, input logic d, input logic [N-1:0] m, input int p);
    cyc_t e;
    e.busy = b;
    e.done = d;
    e.map  = m;
    e.row  = p / COLS;
    e.col  = p % COLS;
    e.l    = exp_left(p);
    e.t    = exp_top(p);
    cq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b0;
      drive_inputs(1'b0);
      rmac_bottom_out = W'($urandom);
      push(1'b0, 1'b0, '0, 0);
    end
  endtask

  // One scan: rst_at >= 0 pulses rst in that cycle of the scan; dup_at pulses start while
  // busy (-2 picks a random busy cycle, -1 none).
  task automatic scan(input logic [N-1:0] faults, input bit sof, input int rst_at,
                      input int dup_at, input bit directed);
    int last, dj, len, k, p, dup;
    res_t r;
    last = N - 1;
    if (sof) for (int i = N - 1; i >= 0; i--) if (faults[i]) last = i;
    dj  = (last + 1) * (S + 1);
    len = (rst_at >= 0) ? rst_at + 4 : dj + 3;
    dup = (dup_at == -2) ? int'($urandom_range(0, dj - 1)) : dup_at;
    @(posedge clk); #1;
    start = 1'b1;
    stop_on_fail = sof;
    drive_inputs(directed);
    rmac_bottom_out = W'($urandom);
    k = 0;
    for (int j = 0; j < len; j++) begin
      @(posedge clk); #1;
      if (j == 0) begin
        k = cyc;
        if (rst_at < 0) begin
          r.map = faults & first_bits(last + 1);
          r.row = last / COLS;
          r.col = last % COLS;
          r.at  = k + dj;
          rq.push_back(r);
        end
      end
      start = (j == dup);
      stop_on_fail = 1'($urandom);
      rst = (j == rst_at);
      drive_inputs(directed);
      rmac_bottom_out = W'($urandom);
      if (rst_at >= 0 && j > rst_at) begin
        push(1'b0, 1'b0, '0, 0);
      end else if (j < dj) begin
        p = j / (S + 1);
        push(1'b1, 1'b0, faults & first_bits(p), p);
        if (j % (S + 1) == S)
          rmac_bottom_out = vw[p] ^ (faults[p] ? W'($urandom_range(1, (1 << W) - 1)) : W'(0));
      end else begin
        push(1'b0, 1'b1, faults & first_bits(last + 1), last);
      end
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    cyc_t e;
    res_t r;
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cq.size() > 0) begin
        e = cq.pop_front();
        chk("busy", 64'(busy), 64'(e.busy));
        chk("done", 64'(done), 64'(e.done));
        chk("fault_map", 64'(fault_map), 64'(e.map));
        chk("fault_count", 64'(fault_count), 64'($countones(e.map)));
        chk("fail", 64'(fail), 64'(|e.map));
        chk("cur_row", 64'(cur_row), 64'(e.row));
        chk("cur_col", 64'(cur_col), 64'(e.col));
        chk("rmac_left_in", 64'(rmac_left_in), 64'(e.l));
        chk("rmac_top_in", 64'(rmac_top_in), 64'(e.t));
      end
      if (done === 1'b1 && done_prev !== 1'b1) begin
        if (rq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done at cycle %0d: got done=1 expected no completion", cyc);
        end else begin
          r = rq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(r.at));
          chk("final_map", 64'(fault_map), 64'(r.map));
          chk("final_count", 64'(fault_count), 64'($countones(r.map)));
          chk("final_row", 64'(cur_row), 64'(r.row));
          chk("final_col", 64'(cur_col), 64'(r.col));
        end
      end
      done_prev = done;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    idle(3);
    scan(4'b0000, 1'b0, -1, -1, 1'b0);
    scan(4'b0100, 1'b0, -1, -1, 1'b0);
    scan(4'b0100, 1'b1, -1, -1, 1'b0);
    scan(4'b1111, 1'b0, -1, -1, 1'b1);
    scan(4'b0001, 1'b0,  7, -1, 1'b0);
    scan(4'b0010, 1'b1, -1,  6, 1'b0);
    for (int i = 0; i < 8; i++)
      scan(N'($urandom), 1'($urandom), -1, -2, 1'($urandom));
    @(negedge clk); #1;
    chk("pending_cycle_checks", 64'(cq.size()), 64'(0));
    chk("pending_done", 64'(rq.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
